// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: sizing, ROB tag type, entry layout and
// the packets exchanged with dispatch, the CDB and the rename map table.
// Tag 0 is reserved as "no tag"; a live slot's tag is its index plus one.
package reorder_buffer_pkg;

    localparam int ROB_SZ = 8;
    localparam int TAG_W  = $clog2(ROB_SZ + 1);
    localparam int PTR_W  = $clog2(ROB_SZ);
    localparam int CNT_W  = PTR_W + 1;

    typedef logic [TAG_W-1:0] rob_tag_t;
    typedef logic [PTR_W-1:0] rob_ptr_t;
    typedef logic [CNT_W-1:0] rob_cnt_t;

    localparam rob_tag_t ZERO_TAG = '0;

    typedef struct packed {
        logic        valid;
        logic        complete;
        logic        has_dest;
        logic [4:0]  dest_reg_idx;
        logic [31:0] value;
        logic [31:0] pc;
    } rob_entry_t;

    typedef struct packed {
        logic [4:0]  dest_reg_idx;
        logic        has_dest;
        logic [31:0] pc;
    } dp_packet_t;

    typedef struct packed {
        rob_tag_t    rob_tag;
        logic [31:0] value;
    } cdb_packet_t;

    typedef struct packed {
        rob_tag_t rob_tag;
        logic     t_plus;
    } map_packet_t;

    typedef struct packed {
        map_packet_t map_packet_a;
        map_packet_t map_packet_b;
    } map_rob_packet_t;

    typedef struct packed {
        rob_tag_t rob_tag;
    } rob_tag_packet_t;

    typedef struct packed {
        logic            retire_valid;
        rob_tag_packet_t rob_head;
        rob_tag_packet_t rob_new_tail;
    } rob_map_packet_t;

    function automatic rob_tag_t ptr_to_tag(input rob_ptr_t ptr);
        return rob_tag_t'(ptr) + rob_tag_t'(1);
    endfunction

    function automatic rob_ptr_t tag_to_ptr(input rob_tag_t tag);
        return rob_ptr_t'(tag - rob_tag_t'(1));
    endfunction

    function automatic logic tag_in_range(input rob_tag_t tag);
        return (tag != ZERO_TAG) && (int'(tag) <= ROB_SZ);
    endfunction

endpackage

// File: rtl/reorder_buffer_ptr.sv
// rob_ptr: wrapping ROB pointer with increment enable and clear.
// ROB_SZ is a power of two, so natural binary overflow gives the wrap.
module rob_ptr
    import reorder_buffer_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    input  logic     clear,
    input  logic     inc,
    output rob_ptr_t ptr
);

    rob_ptr_t ptr_q;
    rob_ptr_t ptr_d;

    // Clear wins over increment so a flush lands the pointer on slot 0.
    always_comb begin
        ptr_d = ptr_q;
        if (clear) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + rob_ptr_t'(1);
        end
    end

    // Pointer register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular ROB that allocates tags at dispatch, captures CDB
// results and retires in order, feeding the rename map table.
// Optional feature macro: ROB_SQUASH_EN adds a squash port that flushes all
// entries; without it entries leave only via retire or reset.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
`ifdef ROB_SQUASH_EN
    input  logic            squash,
`endif
    input  logic            dispatch_valid,
    input  dp_packet_t      dp_packet,
    input  cdb_packet_t     cdb_packet,
    input  map_rob_packet_t map_rob_packet,
    output rob_map_packet_t rob_map_packet,
    output logic            rob_full,
    output logic [31:0]     value_a,
    output logic [31:0]     value_b,
    output logic            value_a_valid,
    output logic            value_b_valid,
    output logic [4:0]      retire_dest_idx,
    output logic [31:0]     retire_value
);

    rob_entry_t entries_q [ROB_SZ];
    rob_entry_t entries_d [ROB_SZ];
    rob_cnt_t   count_q;
    rob_cnt_t   count_d;
    rob_ptr_t   head;
    rob_ptr_t   tail;
    rob_ptr_t   cdb_idx;
    logic       squash_i;
    logic       dispatch_accept;
    logic       retire_fire;

`ifdef ROB_SQUASH_EN
    assign squash_i = squash;
`else
    assign squash_i = 1'b0;
`endif

    // Full is taken from the registered count only, so a retiring full ROB
    // still refuses dispatch that cycle.
    assign rob_full        = (count_q == rob_cnt_t'(ROB_SZ));
    assign dispatch_accept = dispatch_valid && !rob_full && !squash_i;
    assign retire_fire     = rob_map_packet.retire_valid;
    assign cdb_idx         = tag_to_ptr(cdb_packet.rob_tag);

    rob_ptr u_head_ptr (
        .clock (clock),
        .reset (reset),
        .clear (squash_i),
        .inc   (retire_fire),
        .ptr   (head)
    );

    rob_ptr u_tail_ptr (
        .clock (clock),
        .reset (reset),
        .clear (squash_i),
        .inc   (dispatch_accept),
        .ptr   (tail)
    );

    // Operand read: a same-cycle CDB broadcast of the tag bypasses the slot.
    function automatic logic [32:0] operand_read(input map_packet_t mp,
                                                 input cdb_packet_t cdb,
                                                 input rob_entry_t  entry);
        logic        hit;
        logic        ok;
        logic [31:0] val;
        hit = (mp.rob_tag != ZERO_TAG) && (cdb.rob_tag == mp.rob_tag);
        ok  = tag_in_range(mp.rob_tag) && mp.t_plus && (entry.complete || hit);
        if (mp.rob_tag == ZERO_TAG) begin
            val = '0;
        end else if (hit) begin
            val = cdb.value;
        end else begin
            val = entry.value;
        end
        return {ok, val};
    endfunction

    // Head-of-ROB retire view and tag outputs for the map table.
    always_comb begin
        rob_map_packet = '0;
        rob_map_packet.retire_valid = entries_q[head].valid && entries_q[head].complete && !squash_i;
        rob_map_packet.rob_head.rob_tag     = ptr_to_tag(head);
        rob_map_packet.rob_new_tail.rob_tag = ptr_to_tag(tail);
        retire_dest_idx = entries_q[head].has_dest ? entries_q[head].dest_reg_idx : 5'd0;
        retire_value    = entries_q[head].value;
    end

    // Combinational operand reads for both map tags.
    always_comb begin
        {value_a_valid, value_a} = operand_read(map_rob_packet.map_packet_a, cdb_packet,
                                                entries_q[tag_to_ptr(map_rob_packet.map_packet_a.rob_tag)]);
        {value_b_valid, value_b} = operand_read(map_rob_packet.map_packet_b, cdb_packet,
                                                entries_q[tag_to_ptr(map_rob_packet.map_packet_b.rob_tag)]);
    end

    // Next entry state: CDB completion, dispatch allocation, retire release.
    always_comb begin
        entries_d = entries_q;
        count_d   = count_q;
        if (squash_i) begin
            for (int i = 0; i < ROB_SZ; i++) begin
                entries_d[i] = '0;
            end
            count_d = '0;
        end else begin
            if (tag_in_range(cdb_packet.rob_tag) && entries_q[cdb_idx].valid) begin
                entries_d[cdb_idx].complete = 1'b1;
                entries_d[cdb_idx].value    = cdb_packet.value;
            end
            if (dispatch_accept) begin
                entries_d[tail]              = '0;
                entries_d[tail].valid        = 1'b1;
                entries_d[tail].has_dest     = dp_packet.has_dest;
                entries_d[tail].dest_reg_idx = dp_packet.dest_reg_idx;
                entries_d[tail].pc           = dp_packet.pc;
            end
            if (retire_fire) begin
                entries_d[head] = '0;
            end
            if (dispatch_accept && !retire_fire) begin
                count_d = count_q + rob_cnt_t'(1);
            end else if (!dispatch_accept && retire_fire) begin
                count_d = count_q - rob_cnt_t'(1);
            end
        end
    end

    // Entry array and occupancy registers; reset beats every other event.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ROB_SZ; i++) begin
                entries_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios plus randomized traffic against a
// queue-based ROB model; retires are checked by a separate monitor that pops
// a scoreboard of expected retirements. Build with ROB_SQUASH_EN to cover squash.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic            clock;
    logic            reset;
    logic            squash_drv;
    logic            dispatch_valid;
    dp_packet_t      dp_packet;
    cdb_packet_t     cdb_packet;
    map_rob_packet_t map_rob_packet;
    rob_map_packet_t rob_map_packet;
    logic            rob_full;
    logic [31:0]     value_a;
    logic [31:0]     value_b;
    logic            value_a_valid;
    logic            value_b_valid;
    logic [4:0]      retire_dest_idx;
    logic [31:0]     retire_value;

    typedef struct {
        int          tag;
        int          dest;
        logic [31:0] value;
    } exp_t;

    exp_t        exp_q[$];
    int          inflight_q[$];
    logic        m_valid    [ROB_SZ];
    logic        m_complete [ROB_SZ];
    int          m_dest     [ROB_SZ];
    logic [31:0] m_value    [ROB_SZ];
    int          dispatched;
    int          tests_run;
    int          tests_failed;

    reorder_buffer dut (
        .clock           (clock),
        .reset           (reset),
`ifdef ROB_SQUASH_EN
        .squash          (squash_drv),
`endif
        .dispatch_valid  (dispatch_valid),
        .dp_packet       (dp_packet),
        .cdb_packet      (cdb_packet),
        .map_rob_packet  (map_rob_packet),
        .rob_map_packet  (rob_map_packet),
        .rob_full        (rob_full),
        .value_a         (value_a),
        .value_b         (value_b),
        .value_a_valid   (value_a_valid),
        .value_b_valid   (value_b_valid),
        .retire_dest_idx (retire_dest_idx),
        .retire_value    (retire_value)
    );

    // Free-running clock, period 10.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < ROB_SZ; i++) begin
            m_valid[i]    = 1'b0;
            m_complete[i] = 1'b0;
            m_dest[i]     = 0;
            m_value[i]    = '0;
        end
        inflight_q.delete();
        dispatched = 0;
    endtask

    // Tag the next accepted dispatch receives: tags cycle 1..ROB_SZ from a flush.
    function automatic int next_tag();
        return (dispatched % ROB_SZ) + 1;
    endfunction

    function automatic logic [32:0] model_operand(input int tag, input logic tp);
        logic        hit;
        logic [31:0] v;
        if (tag == 0) return 33'd0;
        hit = (int'(cdb_packet.rob_tag) == tag);
        v   = hit ? cdb_packet.value : m_value[tag-1];
        return {tp && (m_complete[tag-1] || hit), v};
    endfunction

    task automatic applyStimulus(input logic dv, input logic [4:0] dest, input logic hd,
                                 input int cdb_tag, input logic [31:0] cdb_val,
                                 input int a_tag, input logic a_tp,
                                 input int b_tag, input logic b_tp,
                                 input logic rst, input logic sq);
        reset                                = rst;
        squash_drv                           = sq;
        dispatch_valid                       = dv;
        dp_packet.dest_reg_idx               = dest;
        dp_packet.has_dest                   = hd;
        dp_packet.pc                         = $urandom;
        cdb_packet.rob_tag                   = rob_tag_t'(cdb_tag);
        cdb_packet.value                     = cdb_val;
        map_rob_packet.map_packet_a.rob_tag  = rob_tag_t'(a_tag);
        map_rob_packet.map_packet_a.t_plus   = a_tp;
        map_rob_packet.map_packet_b.rob_tag  = rob_tag_t'(b_tag);
        map_rob_packet.map_packet_b.t_plus   = b_tp;
    endtask

    task automatic idle_inputs();
        applyStimulus(1'b0, 5'd0, 1'b0, 0, 32'd0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    // Mid-cycle: compare combinational outputs with the model and enqueue the
    // retirement the model expects this cycle.
    task automatic predict();
        logic        exp_ret;
        logic [32:0] op;
        int          ht;
        exp_t        e;
        #2;
        if (reset) return;
        exp_ret = !squash_drv && (inflight_q.size() > 0) && m_complete[inflight_q[0]-1];
        ht      = (inflight_q.size() > 0) ? inflight_q[0] : next_tag();
        checkOutput("rob_full", 32'(rob_full), 32'(inflight_q.size() == ROB_SZ));
        checkOutput("new_tail_tag", 32'(rob_map_packet.rob_new_tail.rob_tag), 32'(next_tag()));
        checkOutput("head_tag", 32'(rob_map_packet.rob_head.rob_tag), 32'(ht));
        checkOutput("retire_valid", 32'(rob_map_packet.retire_valid), 32'(exp_ret));
        if (exp_ret) begin
            e.tag   = ht;
            e.dest  = m_dest[ht-1];
            e.value = m_value[ht-1];
            exp_q.push_back(e);
        end
        op = model_operand(int'(map_rob_packet.map_packet_a.rob_tag), map_rob_packet.map_packet_a.t_plus);
        checkOutput("value_a", value_a, op[31:0]);
        checkOutput("value_a_valid", 32'(value_a_valid), 32'(op[32]));
        op = model_operand(int'(map_rob_packet.map_packet_b.rob_tag), map_rob_packet.map_packet_b.t_plus);
        checkOutput("value_b", value_b, op[31:0]);
        checkOutput("value_b_valid", 32'(value_b_valid), 32'(op[32]));
    endtask

    // Clock edge: apply the same cycle's events to the model.
    task automatic advance();
        logic accept;
        logic ret;
        int   ct;
        int   t;
        accept = dispatch_valid && (inflight_q.size() < ROB_SZ);
        ret    = (inflight_q.size() > 0) && m_complete[inflight_q[0]-1];
        ct     = int'(cdb_packet.rob_tag);
        @(posedge clock);
        if (reset || squash_drv) begin
            model_clear();
        end else begin
            if (ct != 0 && ct <= ROB_SZ && m_valid[ct-1]) begin
                m_complete[ct-1] = 1'b1;
                m_value[ct-1]    = cdb_packet.value;
            end
            if (ret) begin
                t = inflight_q.pop_front();
                m_valid[t-1]    = 1'b0;
                m_complete[t-1] = 1'b0;
                m_dest[t-1]     = 0;
                m_value[t-1]    = '0;
            end
            if (accept) begin
                t = next_tag();
                dispatched++;
                m_valid[t-1]    = 1'b1;
                m_complete[t-1] = 1'b0;
                m_dest[t-1]     = dp_packet.has_dest ? int'(dp_packet.dest_reg_idx) : 0;
                m_value[t-1]    = '0;
                inflight_q.push_back(t);
            end
        end
        #1;
    endtask

    task automatic step();
        predict();
        advance();
    endtask

    // Monitor: every DUT retirement must match the oldest expected one.
    always @(negedge clock) begin : retire_monitor
        exp_t e;
        if (!reset && rob_map_packet.retire_valid) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_retire: got tag %0d expected no retire",
                         rob_map_packet.rob_head.rob_tag);
            end else begin
                e = exp_q.pop_front();
                checkOutput("retire_tag", 32'(rob_map_packet.rob_head.rob_tag), 32'(e.tag));
                checkOutput("retire_dest_idx", 32'(retire_dest_idx), 32'(e.dest));
                checkOutput("retire_value", retire_value, e.value);
            end
        end
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        model_clear();
        applyStimulus(1'b0, 5'd0, 1'b0, 0, 32'd0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        step();
        step();

        // Fill with r1..r8, then a rejected ninth dispatch.
        idle_inputs();
        predict();
        checkOutput("reset_rob_full", 32'(rob_full), 32'd0);
        checkOutput("reset_new_tail", 32'(rob_map_packet.rob_new_tail.rob_tag), 32'd1);
        advance();
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 5'(i), 1'b1, 0, 32'd0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
            step();
        end
        checkOutput("full_after_8", 32'(rob_full), 32'd1);
        applyStimulus(1'b1, 5'd9, 1'b1, 0, 32'd0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("tail_held_after_reject", 32'(rob_map_packet.rob_new_tail.rob_tag), 32'd1);

        // Out-of-order completion, then in-order retire of tags 1, 2, 3.
        applyStimulus(1'b0, 5'd0, 1'b0, 3, 32'hAA, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        predict();
        checkOutput("no_retire_tag3_only", 32'(rob_map_packet.retire_valid), 32'd0);
        advance();
        applyStimulus(1'b0, 5'd0, 1'b0, 1, 32'h11, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 5'd0, 1'b0, 2, 32'h22, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        step();
        idle_inputs();
        step();
        predict();
        checkOutput("retire3_tag", 32'(rob_map_packet.rob_head.rob_tag), 32'd3);
        checkOutput("retire3_value", retire_value, 32'hAA);
        advance();

        // Refill to full, then a full ROB retiring while dispatch is offered.
        for (int i = 10; i <= 12; i++) begin
            applyStimulus(1'b1, 5'(i), 1'b1, 0, 32'd0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
            step();
        end
        applyStimulus(1'b0, 5'd0, 1'b0, 4, 32'h44, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 5'd13, 1'b0, 0, 32'd0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        predict();
        checkOutput("full_retire_valid", 32'(rob_map_packet.retire_valid), 32'd1);
        advance();
        checkOutput("count7_not_full", 32'(rob_full), 32'd0);
        checkOutput("tail_after_reject", 32'(rob_map_packet.rob_new_tail.rob_tag), 32'd4);
        applyStimulus(1'b1, 5'd14, 1'b1, 0, 32'd0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("refull_after_accept", 32'(rob_full), 32'd1);

        // Operand bypass from the CDB, then the reserved tag.
        applyStimulus(1'b0, 5'd0, 1'b0, 5, 32'h1234, 5, 1'b1, 6, 1'b1, 1'b0, 1'b0);
        predict();
        checkOutput("bypass_value_a", value_a, 32'h1234);
        checkOutput("bypass_value_a_valid", 32'(value_a_valid), 32'd1);
        advance();
        applyStimulus(1'b0, 5'd0, 1'b0, 0, 32'd0, 0, 1'b1, 5, 1'b1, 1'b0, 1'b0);
        predict();
        checkOutput("tag0_value_a_valid", 32'(value_a_valid), 32'd0);
        advance();

        // Reset with live entries and a dispatch pending.
        applyStimulus(1'b0, 5'd0, 1'b0, 0, 32'd0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        step();
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 5'(i), 1'b1, 0, 32'd0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
            step();
        end
        applyStimulus(1'b0, 5'd0, 1'b0, 1, 32'h5, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 5'd7, 1'b1, 0, 32'd0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        step();
        idle_inputs();
        predict();
        checkOutput("post_reset_retire_valid", 32'(rob_map_packet.retire_valid), 32'd0);
        checkOutput("post_reset_rob_full", 32'(rob_full), 32'd0);
        checkOutput("post_reset_new_tail", 32'(rob_map_packet.rob_new_tail.rob_tag), 32'd1);
        advance();

`ifdef ROB_SQUASH_EN
        // Squash alongside a retire-ready head and a dispatch.
        for (int i = 1; i <= 2; i++) begin
            applyStimulus(1'b1, 5'(i), 1'b1, 0, 32'd0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
            step();
        end
        applyStimulus(1'b0, 5'd0, 1'b0, 1, 32'h77, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 5'd3, 1'b1, 0, 32'd0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        predict();
        checkOutput("squash_retire_valid", 32'(rob_map_packet.retire_valid), 32'd0);
        advance();
        applyStimulus(1'b0, 5'd0, 1'b0, 0, 32'd0, 1, 1'b1, 2, 1'b1, 1'b0, 1'b0);
        predict();
        checkOutput("post_squash_new_tail", 32'(rob_map_packet.rob_new_tail.rob_tag), 32'd1);
        checkOutput("post_squash_slot1_valid", 32'(value_a_valid), 32'd0);
        advance();
`endif

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            int   ct;
            int   at;
            logic sq;
            if (inflight_q.size() > 0 && ($urandom % 4) != 0) begin
                ct = inflight_q[$urandom_range(0, inflight_q.size() - 1)];
            end else begin
                ct = $urandom_range(0, ROB_SZ);
            end
            at = (($urandom % 4) == 0) ? ct : $urandom_range(0, ROB_SZ);
`ifdef ROB_SQUASH_EN
            sq = (($urandom % 40) == 0);
`else
            sq = 1'b0;
`endif
            applyStimulus(($urandom % 3) != 0, 5'($urandom_range(0, 31)), 1'($urandom % 2),
                          ct, $urandom, at, 1'($urandom % 2),
                          $urandom_range(0, ROB_SZ), 1'($urandom % 2),
                          ($urandom % 128) == 0, sq);
            step();
        end

        idle_inputs();
        step();
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
